// File: rtl/xnor_dot_sequencer_pkg.sv
// Shared constants and FSM state encoding for the XNOR dot-product sequencer.
package xnor_dot_sequencer_pkg;

    localparam int CHUNK_W = 128;
    localparam int POP_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

endpackage

// File: rtl/xnor_dot_sequencer_popcount.sv
// Two-stage popcount of xi ~^ wi: four 32-bit partial counts, then their sum.
module xnor_popcount_128_pipe
    import xnor_dot_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [CHUNK_W-1:0] xi,
    input  logic [CHUNK_W-1:0] wi,
    output logic               out_valid,
    output logic [POP_W-1:0]   count
);
    localparam int STAGES = 2;
    localparam int PARTS  = 4;
    localparam int PART_W = CHUNK_W / PARTS;

    logic [STAGES:0]             vld_pipe;
    logic [CHUNK_W-1:0]          match;
    logic [PARTS-1:0][5:0]       part_q;
    logic [POP_W-1:0]            count_q;

    function automatic logic [5:0] pop32(input logic [PART_W-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < PART_W; i++) c = c + 6'(v[i]);
        return c;
    endfunction

    assign match       = xi ~^ wi;
    assign vld_pipe[0] = in_valid;

    // Only the valid tags are reset; data lanes are don't-care while untagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe[STAGES:1] <= '0;
        else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    always_ff @(posedge clk) begin
        for (int g = 0; g < PARTS; g++) part_q[g] <= pop32(match[g*PART_W +: PART_W]);
        count_q <= POP_W'(part_q[0]) + POP_W'(part_q[1]) + POP_W'(part_q[2]) + POP_W'(part_q[3]);
    end

    assign out_valid = vld_pipe[STAGES];
    assign count     = count_q;

endmodule

// File: rtl/xnor_dot_sequencer.sv
// Accumulates XNOR popcounts over CHUNKS 128-bit chunks and thresholds the total.
module xnor_dot_sequencer
    import xnor_dot_sequencer_pkg::*;
#(
    parameter int CHUNKS = 8,
    parameter int ACC_W  = $clog2(128*CHUNKS+1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHUNK_W-1:0] xi,
    input  logic [CHUNK_W-1:0] wi,
    input  logic [ACC_W-1:0]   thresh,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_count,
    output logic               out_act
);
    localparam int CNT_W = $clog2(CHUNKS+1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [ACC_W-1:0]   thr_q, thr_nxt;
    logic               ld_out;
    logic               take;
    logic               pv;
    logic [POP_W-1:0]   pc;

    xnor_popcount_128_pipe u_pop (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (take),
        .xi        (xi),
        .wi        (wi),
        .out_valid (pv),
        .count     (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            thr_q     <= '0;
            out_count <= '0;
            out_act   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
            thr_q <= thr_nxt;
            if (ld_out) begin
                out_count <= acc_nxt;
                out_act   <= (acc_nxt >= thr_q);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        thr_nxt   = thr_q;
        ld_out    = 1'b0;
        acc_nxt   = acc + (pv ? ACC_W'(pc) : '0);
        in_ready  = (state == IDLE) || (state == ACCUM);
        out_valid = (state == OUTPUT);
        take      = in_valid && in_ready;
        case (state)
            IDLE: begin
                if (take) begin
                    acc_nxt = '0;
                    thr_nxt = thresh;
                    if (CHUNKS == 1) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ACCUM;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ACCUM: begin
                if (take) begin
                    if (cnt == CNT_W'(CHUNKS-1)) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Counter doubles as a drain timer: the last chunk's count lands on the second DRAIN cycle.
                if (cnt == CNT_W'(1)) begin
                    state_nxt = OUTPUT;
                    cnt_nxt   = '0;
                    ld_out    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            OUTPUT: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_xnor_dot_sequencer.sv
// Scoreboard bench: expected count/act pushed per vector, popped on output transfer.
module tb_xnor_dot_sequencer;
    localparam int CH  = 8;
    localparam int AW  = $clog2(128*CH+1);
    localparam int AW1 = $clog2(128+1);

    typedef struct packed {
        logic [AW-1:0] cnt;
        logic          act;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_act;
    logic [127:0]   xi = '0, wi = '0;
    logic [AW-1:0]  thresh = '0, out_count;

    logic           in_valid_1 = 1'b0, in_ready_1, out_valid_1, out_act_1;
    logic [127:0]   xi_1 = '0, wi_1 = '0;
    logic [AW1-1:0] thresh_1 = '0, out_count_1;

    exp_t           sb[$];
    logic [127:0]   vx[CH], vw[CH];
    int             checks = 0, failures = 0;
    int             cyc = 0, stall_exp = 0, stall_cnt = 0;
    int             xfer_edge = 0, acc_edge = 0, first_acc = 0;
    logic           was_stalled = 1'b0, prev_act;
    logic [AW-1:0]  prev_cnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xnor_dot_sequencer #(.CHUNKS(CH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .xi(xi), .wi(wi), .thresh(thresh), .out_valid(out_valid),
        .out_ready(out_ready), .out_count(out_count), .out_act(out_act)
    );

    xnor_dot_sequencer #(.CHUNKS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1),
        .xi(xi_1), .wi(wi_1), .thresh(thresh_1), .out_valid(out_valid_1),
        .out_ready(1'b1), .out_count(out_count_1), .out_act(out_act_1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            chk("in_ready_in_output", in_ready, 0);
            if (was_stalled) begin
                chk("hold_count", out_count, prev_cnt);
                chk("hold_act", out_act, prev_act);
            end
            if (out_ready) begin
                chk("stall_len", stall_cnt, stall_exp);
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("count", out_count, e.cnt);
                    chk("act", out_act, e.act);
                end
                xfer_edge   = cyc + 1;
                stall_cnt   = 0;
                was_stalled = 1'b0;
            end else begin
                stall_cnt++;
                was_stalled = 1'b1;
                prev_cnt    = out_count;
                prev_act    = out_act;
            end
        end
    end

    task automatic send_chunk(input logic [127:0] x, input logic [127:0] w);
        int n = 0;
        in_valid = 1'b1; xi = x; wi = w;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        acc_edge = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [AW-1:0] thr, input int gap_at, input int gap_len);
        int   tot = 0;
        exp_t e;
        for (int k = 0; k < CH; k++) tot += $countones(vx[k] ~^ vw[k]);
        e.cnt = AW'(tot);
        e.act = (tot >= int'(thr));
        sb.push_back(e);
        thresh = thr;
        for (int k = 0; k < CH; k++) begin
            send_chunk(vx[k], vw[k]);
            if (k == 0) begin
                first_acc = acc_edge;
                thresh    = ~thr;
            end
            if (k == gap_at)
                repeat (gap_len) begin @(negedge clk); chk("gap_in_ready", in_ready, 1); end
        end
    endtask

    task automatic fill_matches(input int base, input int step);
        logic [127:0] ones;
        ones = '1;
        for (int k = 0; k < CH; k++) begin
            vw[k] = {$urandom, $urandom, $urandom, $urandom};
            vx[k] = vw[k] ^ (ones << (base + step*k));
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("sb_drain", sb.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_act", out_act, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // all matching, thresh 512
        fill_matches(128, 0);
        send_vec(AW'(512), -1, 0);
        wait_drain();

        // all mismatching, thresh 1
        for (int k = 0; k < CH; k++) begin vw[k] = {$urandom, $urandom, $urandom, $urandom}; vx[k] = ~vw[k]; end
        send_vec(AW'(1), -1, 0);
        wait_drain();

        // chunk k has 16*k matches, 3-cycle gap after chunk 2; total 448 == thresh
        fill_matches(0, 16);
        send_vec(AW'(448), 2, 3);
        wait_drain();

        // output back-pressure for 5 cycles, next vector queued behind it
        fill_matches(100, 3);
        out_ready = 1'b0;
        stall_exp = 5;
        send_vec(AW'(900), -1, 0);
        fill_matches(120, 1);
        fork
            begin
                int n = 0;
                while (!out_valid && n < 100) begin @(negedge clk); n++; end
                if (n >= 100) chk("ov_timeout", 0, 1);
                repeat (5) @(posedge clk); #1;
                out_ready = 1'b1;
                @(posedge clk); #1;
                stall_exp = 0;
            end
            send_vec(AW'(1000), -1, 0);
        join
        chk("next_accept", first_acc, xfer_edge + 1);
        wait_drain();

        // random vectors
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < CH; k++) begin
                vx[k] = {$urandom, $urandom, $urandom, $urandom};
                vw[k] = {$urandom, $urandom, $urandom, $urandom};
            end
            send_vec(AW'($urandom_range(0, 1024)), -1, 0);
        end
        wait_drain();

        // reset after 4 of 8 chunks discards the vector
        fill_matches(128, 0);
        for (int k = 0; k < 4; k++) send_chunk(vx[k], vw[k]);
        @(negedge clk); #2 rst = 1'b1; #3 rst = 1'b0;
        repeat (12) begin @(negedge clk); chk("no_ov_after_rst", out_valid, 0); end
        chk("rst_mid_count", out_count, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        fill_matches(128, 0);
        send_vec(AW'(1024), -1, 0);
        wait_drain();

        // single-chunk instance: xi==wi, thresh 129
        begin
            int e1, n;
            xi_1 = {$urandom, $urandom, $urandom, $urandom};
            wi_1 = xi_1;
            thresh_1 = AW1'(129);
            in_valid_1 = 1'b1;
            @(posedge clk); #1;
            e1 = cyc;
            in_valid_1 = 1'b0;
            n = 0;
            @(negedge clk);
            while (!out_valid_1 && n < 50) begin @(negedge clk); n++; end
            chk("c1_latency", cyc - e1, 2);
            chk("c1_count", out_count_1, 128);
            chk("c1_act", out_act_1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
